// File: rtl/memory_access_stage_p.sv
// memory_access_stage_p: RV32 M stage with word-organised data memory, B/H/W load-store, misalignment detect and M/W register (in: M-stage controls/data, out: registered W-stage fields)
module memory_access_stage_p #(
  parameter int XLEN = 32,
  parameter int DMEM_DEPTH = 256,
  parameter int ADDR_W = $clog2(DMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            EnW,
  input  logic            FlushW,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic            MemWriteM,
  input  logic            MemReadM,
  input  logic [2:0]      Funct3M,
  input  logic [4:0]      RDM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [4:0]      RDW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic            MisalignW
);
  logic [XLEN-1:0] mem [DMEM_DEPTH] = '{default: '0};
  logic [ADDR_W-1:0] widx;
  logic [1:0] lane;
  logic is_b, is_h, is_u, misal, mis_acc, we;
  logic [3:0] be;
  logic [XLEN-1:0] wdat, word, ldat;
  logic [7:0] bsel;
  logic [15:0] hsel;
  assign widx = ALUResultM[ADDR_W+1:2];
  assign lane = ALUResultM[1:0];
  always_comb begin
    is_b = Funct3M[1:0] == 2'b00;
    is_h = Funct3M[1:0] == 2'b01;
    is_u = Funct3M[2];
    misal = is_h ? lane[0] : !is_b && lane != 2'b00;
    mis_acc = (MemReadM | MemWriteM) & misal;
    we = MemWriteM & EnW & ~FlushW & ~rst & ~misal;
    be = is_b ? 4'b0001 << lane : is_h ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdat = is_b ? {4{WriteDataM[7:0]}} : is_h ? {2{WriteDataM[15:0]}} : WriteDataM;
    word = mem[widx];
    bsel = word[8*lane +: 8];
    hsel = word[16*lane[1] +: 16];
    ldat = is_b ? {{(XLEN-8){~is_u & bsel[7]}}, bsel} : is_h ? {{(XLEN-16){~is_u & hsel[15]}}, hsel} : word;
  end
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wdat[8*i +: 8];
  always_ff @(posedge clk)
    if (rst || FlushW) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RDW        <= '0;
      PCPlus4W   <= '0;
      MisalignW  <= 1'b0;
    end else if (EnW) begin
      RegWriteW  <= RegWriteM & ~mis_acc;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= mis_acc ? '0 : ldat;
      RDW        <= RDM;
      PCPlus4W   <= PCPlus4M;
      MisalignW  <= mis_acc;
    end
endmodule
